ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 16 +
 rtl/ex_alu.sv | 29 ++
 rtl/ex_stage.sv | 134 +++++++++++++
 tb/tb_ex_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - ALU opcode encodings and default widths for ex_stage
package ex_stage_pkg;

  localparam int EX_DATA_W_DEFAULT     = 32;
  localparam int EX_REG_ADDR_W_DEFAULT = 5;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b101;
  localparam logic [2:0] ALU_NOR  = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational ALU for the execute stage
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = EX_DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        op_i,
  input  logic [4:0]        shamt_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SLL:  result_o = b_i << shamt_i;
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage with EX/MEM register; EX_OVERFLOW_EN adds overflow_out
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W     = EX_DATA_W_DEFAULT,
  parameter int REG_ADDR_W = EX_REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_RegDst,
  input  logic                  in_RegWrite,
  input  logic                  in_ALUSrc,
  input  logic                  in_MemWrite,
  input  logic                  in_MemRead,
  input  logic                  in_MemToReg,
  input  logic [2:0]            in_ALUOp,
  input  logic [REG_ADDR_W-1:0] in_instr_bits_15_11,
  input  logic [REG_ADDR_W-1:0] in_instr_bits_20_16,
  input  logic [DATA_W-1:0]     in_extended_bits,
  input  logic [DATA_W-1:0]     in_read_data1,
  input  logic [DATA_W-1:0]     in_read_data2,
  input  logic [DATA_W-1:0]     in_new_pc_value,
  input  logic [1:0]            in_load_mode,
  output logic                  zero_out,
`ifdef EX_OVERFLOW_EN
  output logic                  overflow_out,
`endif
  output logic                  RegWrite_out,
  output logic                  MemWrite_out,
  output logic                  MemRead_out,
  output logic                  MemToReg_out,
  output logic [1:0]            load_mode_out,
  output logic [REG_ADDR_W-1:0] writebackDestination_out,
  output logic [DATA_W-1:0]     aluResult_out,
  output logic [DATA_W-1:0]     rt_out,
  output logic [DATA_W-1:0]     pc_out
);

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  logic                  zero_d, zero_q;
  logic                  regwrite_d, regwrite_q;
  logic                  memwrite_d, memwrite_q;
  logic                  memread_d, memread_q;
  logic                  memtoreg_d, memtoreg_q;
  logic [1:0]            load_mode_d, load_mode_q;
  logic [REG_ADDR_W-1:0] wb_dest_d, wb_dest_q;
  logic [DATA_W-1:0]     alu_result_d, alu_result_q;
  logic [DATA_W-1:0]     rt_d, rt_q;
  logic [DATA_W-1:0]     pc_d, pc_q;

  assign alu_b = in_ALUSrc ? in_extended_bits : in_read_data2;

  ex_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (in_read_data1),
    .b_i      (alu_b),
    .op_i     (in_ALUOp),
    .shamt_i  (in_extended_bits[10:6]),
    .result_o (alu_result)
  );

  always_comb begin
    zero_d       = (alu_result == '0);
    regwrite_d   = in_RegWrite;
    memwrite_d   = in_MemWrite;
    memread_d    = in_MemRead;
    memtoreg_d   = in_MemToReg;
    load_mode_d  = in_load_mode;
    wb_dest_d    = in_RegDst ? in_instr_bits_15_11 : in_instr_bits_20_16;
    alu_result_d = alu_result;
    rt_d         = in_read_data2;
    pc_d         = in_new_pc_value + (in_extended_bits << 2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q       <= 1'b0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memtoreg_q   <= 1'b0;
      load_mode_q  <= '0;
      wb_dest_q    <= '0;
      alu_result_q <= '0;
      rt_q         <= '0;
      pc_q         <= '0;
    end else begin
      zero_q       <= zero_d;
      regwrite_q   <= regwrite_d;
      memwrite_q   <= memwrite_d;
      memread_q    <= memread_d;
      memtoreg_q   <= memtoreg_d;
      load_mode_q  <= load_mode_d;
      wb_dest_q    <= wb_dest_d;
      alu_result_q <= alu_result_d;
      rt_q         <= rt_d;
      pc_q         <= pc_d;
    end
  end

`ifdef EX_OVERFLOW_EN
  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips from A.
  logic ovf_d, ovf_q;
  always_comb begin
    ovf_d = 1'b0;
    if (in_ALUOp == ALU_ADD)
      ovf_d = (in_read_data1[DATA_W-1] == alu_b[DATA_W-1]) &&
              (alu_result[DATA_W-1] != in_read_data1[DATA_W-1]);
    else if (in_ALUOp == ALU_SUB)
      ovf_d = (in_read_data1[DATA_W-1] != alu_b[DATA_W-1]) &&
              (alu_result[DATA_W-1] != in_read_data1[DATA_W-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow_out = ovf_q;
`endif

  assign zero_out                 = zero_q;
  assign RegWrite_out             = regwrite_q;
  assign MemWrite_out             = memwrite_q;
  assign MemRead_out              = memread_q;
  assign MemToReg_out             = memtoreg_q;
  assign load_mode_out            = load_mode_q;
  assign writebackDestination_out = wb_dest_q;
  assign aluResult_out            = alu_result_q;
  assign rt_out                   = rt_q;
  assign pc_out                   = pc_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage (table vectors, reset sequences, random vs model)
module tb_ex_stage;

  typedef struct packed {
    logic        regdst, regwrite, alusrc, memwrite, memread, memtoreg;
    logic [2:0]  op;
    logic [4:0]  rd, rt;
    logic [31:0] ext, a, b, npc;
    logic [1:0]  lm;
  } in_t;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] pc;
    logic [4:0]  wb;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_RegDst, in_RegWrite, in_ALUSrc, in_MemWrite, in_MemRead, in_MemToReg;
  logic [2:0]  in_ALUOp;
  logic [4:0]  in_instr_bits_15_11, in_instr_bits_20_16;
  logic [31:0] in_extended_bits, in_read_data1, in_read_data2, in_new_pc_value;
  logic [1:0]  in_load_mode;
  logic        zero_out, RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out;
  logic [1:0]  load_mode_out;
  logic [4:0]  writebackDestination_out;
  logic [31:0] aluResult_out, rt_out, pc_out;
`ifdef EX_OVERFLOW_EN
  logic        overflow_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .in_RegDst                (in_RegDst),
    .in_RegWrite              (in_RegWrite),
    .in_ALUSrc                (in_ALUSrc),
    .in_MemWrite              (in_MemWrite),
    .in_MemRead               (in_MemRead),
    .in_MemToReg              (in_MemToReg),
    .in_ALUOp                 (in_ALUOp),
    .in_instr_bits_15_11      (in_instr_bits_15_11),
    .in_instr_bits_20_16      (in_instr_bits_20_16),
    .in_extended_bits         (in_extended_bits),
    .in_read_data1            (in_read_data1),
    .in_read_data2            (in_read_data2),
    .in_new_pc_value          (in_new_pc_value),
    .in_load_mode             (in_load_mode),
    .zero_out                 (zero_out),
`ifdef EX_OVERFLOW_EN
    .overflow_out             (overflow_out),
`endif
    .RegWrite_out             (RegWrite_out),
    .MemWrite_out             (MemWrite_out),
    .MemRead_out              (MemRead_out),
    .MemToReg_out             (MemToReg_out),
    .load_mode_out            (load_mode_out),
    .writebackDestination_out (writebackDestination_out),
    .aluResult_out            (aluResult_out),
    .rt_out                   (rt_out),
    .pc_out                   (pc_out)
  );

  function automatic in_t mk(logic regdst, logic regwrite, logic alusrc, logic memwrite,
                             logic memread, logic memtoreg, logic [2:0] op, logic [4:0] rd,
                             logic [4:0] rt, logic [31:0] ext, logic [31:0] a,
                             logic [31:0] b, logic [31:0] npc, logic [1:0] lm);
    in_t x;
    x.regdst = regdst; x.regwrite = regwrite; x.alusrc = alusrc; x.memwrite = memwrite;
    x.memread = memread; x.memtoreg = memtoreg; x.op = op; x.rd = rd; x.rt = rt;
    x.ext = ext; x.a = a; x.b = b; x.npc = npc; x.lm = lm;
    return x;
  endfunction

  // Reference model from the arithmetic definitions, using 64-bit integers.
  function automatic exp_t model(in_t x);
    exp_t e;
    longint unsigned m  = 64'h1_0000_0000;
    longint unsigned ua = x.a;
    longint unsigned ub = x.alusrc ? x.ext : x.b;
    int ia = x.a;
    int ib = x.alusrc ? x.ext : x.b;
    longint sa = ia;
    longint sb = ib;
    longint s  = 0;
    longint unsigned r;
    int sh = int'(x.ext[10:6]);
    case (x.op)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd2: r = (sa < sb) ? 1 : 0;
      3'd3: r = (ua < ub) ? 1 : 0;
      3'd4: r = (ua + ub) % m;
      3'd5: r = (ua + m - ub) % m;
      3'd6: r = (m - 1) - (ua | ub);
      default: r = (ub * (64'd1 << sh)) % m;
    endcase
    if (x.op == 3'd4) s = sa + sb;
    if (x.op == 3'd5) s = sa - sb;
    e.alu  = r[31:0];
    e.zero = (r == 0);
    e.pc   = 32'((64'(x.npc) + 64'(x.ext) * 4) % m);
    e.wb   = x.regdst ? x.rd : x.rt;
    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(in_t x);
    in_RegDst = x.regdst; in_RegWrite = x.regwrite; in_ALUSrc = x.alusrc;
    in_MemWrite = x.memwrite; in_MemRead = x.memread; in_MemToReg = x.memtoreg;
    in_ALUOp = x.op; in_instr_bits_15_11 = x.rd; in_instr_bits_20_16 = x.rt;
    in_extended_bits = x.ext; in_read_data1 = x.a; in_read_data2 = x.b;
    in_new_pc_value = x.npc; in_load_mode = x.lm;
  endtask

  task automatic check_out(string tag, in_t x, exp_t e);
    check({tag, ".alu"},  aluResult_out, e.alu);
    check({tag, ".zero"}, 32'(zero_out), 32'(e.zero));
    check({tag, ".pc"},   pc_out, e.pc);
    check({tag, ".wb"},   32'(writebackDestination_out), 32'(e.wb));
    check({tag, ".rt"},   rt_out, x.b);
    check({tag, ".ctl"},  {28'd0, RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out},
          {28'd0, x.regwrite, x.memwrite, x.memread, x.memtoreg});
    check({tag, ".lm"},   32'(load_mode_out), 32'(x.lm));
`ifdef EX_OVERFLOW_EN
    check({tag, ".ovf"},  32'(overflow_out), 32'(model(x).ovf));
`endif
  endtask

  task automatic check_zero(string tag);
    check({tag, ".alu"},  aluResult_out, 32'd0);
    check({tag, ".zero"}, 32'(zero_out), 32'd0);
    check({tag, ".pc"},   pc_out, 32'd0);
    check({tag, ".wb"},   32'(writebackDestination_out), 32'd0);
    check({tag, ".rt"},   rt_out, 32'd0);
    check({tag, ".ctl"},  {28'd0, RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out}, 32'd0);
    check({tag, ".lm"},   32'(load_mode_out), 32'd0);
`ifdef EX_OVERFLOW_EN
    check({tag, ".ovf"},  32'(overflow_out), 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];
  in_t  busy, other, r;

  initial begin
    tbl[0]  = '{mk(1,1,0,0,0,0,3'b100,5'd4,5'd2,32'd0,32'd7,32'd7,32'd0,2'd0),
                '{32'd14, 1'b0, 32'd0, 5'd4, 1'b0}};
    tbl[1]  = '{mk(0,1,0,0,0,0,3'b101,5'd4,5'd2,32'd0,32'd7,32'd7,32'd0,2'd0),
                '{32'd0, 1'b1, 32'd0, 5'd2, 1'b0}};
    tbl[2]  = '{mk(0,1,0,0,0,0,3'b101,5'd4,5'd2,32'd0,32'd7,32'd8,32'd0,2'd0),
                '{32'hFFFF_FFFF, 1'b0, 32'd0, 5'd2, 1'b0}};
    tbl[3]  = '{mk(0,1,1,0,0,0,3'b100,5'd0,5'd1,32'd32,32'd7,32'd5,32'd100,2'd0),
                '{32'd39, 1'b0, 32'd228, 5'd1, 1'b0}};
    tbl[4]  = '{mk(1,0,0,1,1,1,3'b001,5'd9,5'd3,32'd0,32'd1,32'd0,32'd0,2'd2),
                '{32'd1, 1'b0, 32'd0, 5'd9, 1'b0}};
    tbl[5]  = '{mk(0,0,0,1,1,1,3'b001,5'd9,5'd3,32'd0,32'd1,32'd0,32'd0,2'd2),
                '{32'd1, 1'b0, 32'd0, 5'd3, 1'b0}};
    tbl[6]  = '{mk(0,0,0,0,0,0,3'b000,5'd0,5'd0,32'd0,32'h0000_00F0,32'h0000_000F,32'd0,2'd1),
                '{32'd0, 1'b1, 32'd0, 5'd0, 1'b0}};
    tbl[7]  = '{mk(0,0,0,0,0,0,3'b110,5'd0,5'd0,32'd0,32'hFFFF_0000,32'h0000_FFFF,32'd0,2'd3),
                '{32'd0, 1'b1, 32'd0, 5'd0, 1'b0}};
    tbl[8]  = '{mk(0,1,0,0,0,0,3'b111,5'd0,5'd7,32'h0000_0140,32'd0,32'd1,32'h0000_1000,2'd0),
                '{32'd32, 1'b0, 32'h0000_1500, 5'd7, 1'b0}};
    tbl[9]  = '{mk(0,1,0,0,0,0,3'b010,5'd0,5'd5,32'd0,32'hFFFF_FFFF,32'd1,32'd0,2'd0),
                '{32'd1, 1'b0, 32'd0, 5'd5, 1'b0}};
    tbl[10] = '{mk(0,1,0,0,0,0,3'b011,5'd0,5'd5,32'd0,32'hFFFF_FFFF,32'd1,32'd0,2'd0),
                '{32'd0, 1'b1, 32'd0, 5'd5, 1'b0}};
    tbl[11] = '{mk(0,1,1,0,0,0,3'b100,5'd0,5'd6,32'hFFFF_FFFF,32'd1,32'd9,32'd8,2'd0),
                '{32'd0, 1'b1, 32'd4, 5'd6, 1'b0}};

    busy  = mk(1,1,1,1,1,1,3'b100,5'd31,5'd17,32'h0000_0040,32'h1234_5678,32'hCAFE_F00D,32'h0000_4000,2'd3);
    other = mk(0,1,0,0,1,1,3'b001,5'd12,5'd21,32'h0000_0010,32'hA5A5_0000,32'h0000_5A5A,32'h0000_0200,2'd1);

    // Reset with nonzero inputs present.
    rst_n = 1'b0;
    drive(busy);
    step();
    check_zero("reset");
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].i);
      step();
      check_out($sformatf("vec%0d", k), tbl[k].i, tbl[k].e);
    end

    // Mid-stream reset discards the in-flight capture, then tracking resumes next edge.
    drive(busy);
    step();
    check_out("pre_rst", busy, model(busy));
    drive(other);
    rst_n = 1'b0;
    step();
    check_zero("mid_rst");
    rst_n = 1'b1;
    step();
    check_out("post_rst", other, model(other));

    for (int n = 0; n < 400; n++) begin
      r = mk($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,1), $urandom_range(0,1), 3'($urandom_range(0,7)),
             5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom, 2'($urandom));
      case ($urandom_range(0,3))
        0: r.b = r.a;
        1: begin r.a = 32'($urandom_range(0,3)); r.b = 32'($urandom_range(0,3)); r.ext = 32'($urandom_range(0,3)); end
        2: begin r.a = {1'b0, 31'($urandom)} | 32'h7000_0000; r.b = r.a; r.ext = r.a; end
        default: ;
      endcase
      drive(r);
      step();
      check_out("rand", r, model(r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
